// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with storage, parametrised in width and depth.
// The read data is registered. A read and a write can happen in the same cycle,
// including a write into a full FIFO while a read drains it. The block provides
// almost-full/almost-empty thresholds, an occupancy count, and one-cycle
// overflow/underflow pulses for rejected requests.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [CW-1:0]     count_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  // Storage is deliberately left without a reset. Reads only ever return
  // words that were written after the last reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // The pointers carry one extra bit beyond the address.
  // Their difference therefore equals the occupancy, modulo 2*DEPTH.
  logic [CW-1:0]     wptr_q, wptr_d;
  logic [CW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_ok, wr_ok;

  // Flags decode from the registered count only. They never depend on this cycle's requests.
  assign count_o        = count_q;
  assign full_o         = (count_q == CW'(DEPTH));
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= CW'(AFULL_TH));
  assign almost_empty_o = (count_q <= CW'(AEMPTY_TH));
  assign dout_o         = dout_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  // Accept decode: when full, a write gets in only if a read frees a slot in the same cycle.
  always_comb begin
    rd_ok = rd_i & ~empty_o;
    wr_ok = wr_i & (~full_o | rd_ok);
  end

  // Next-state computation for the pointers, count, read data and error pulses.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    overflow_d  = wr_i & ~wr_ok;
    underflow_d = rd_i & ~rd_ok;
    if (wr_ok) begin
      wptr_d = wptr_q + CW'(1);
    end
    if (rd_ok) begin
      rptr_d = rptr_q + CW'(1);
      dout_d = mem_q[rptr_q[AW-1:0]];
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register. An asynchronous reset discards every stored word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write port. There is no bypass, so a word written this cycle is readable from the next one.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wptr_q[AW-1:0]] <= din_i;
    end
  end

  // Structural invariants relating the count to the pointers and to the flags.
  a_count_matches_ptrs : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q == CW'(wptr_q - rptr_q));
  a_not_full_and_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(full_o && empty_o));
  a_count_bounded : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: instance A is 16 deep by 8 bits wide with default thresholds.
// Instance B is 4 deep by 32 bits wide with custom thresholds.
// A queue-based model of each instance predicts count, flags, read data and error pulses.
module tb_sync_fifo_param;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;

  logic        wrA = 1'b0, rdA = 1'b0;
  logic [7:0]  dinA = '0, doutA;
  logic        fullA, emptyA, afA, aeA, ovfA, unfA;
  logic [4:0]  countA;

  logic        wrB = 1'b0, rdB = 1'b0;
  logic [31:0] dinB = '0, doutB;
  logic        fullB, emptyB, afB, aeB, ovfB, unfB;
  logic [2:0]  countB;

  int checks = 0;
  int errors = 0;

  // Model state: a queue holds the stored words; the other fields hold the registered outputs.
  logic [7:0]  qA[$];
  logic [7:0]  mDoutA = '0;
  logic        mOvfA = 1'b0, mUnfA = 1'b0;
  logic [31:0] qB[$];
  logic [31:0] mDoutB = '0;
  logic        mOvfB = 1'b0, mUnfB = 1'b0;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    int         expCount;
    logic [7:0] expDout;
    logic       expOvf;
    logic       expUnf;
  } vec_t;

  vec_t vecs[9];

  sync_fifo_param #(.DATA_W(8), .DEPTH(16)) dutA (
    .clk_i(clk), .rst_ni(rstN), .wr_i(wrA), .din_i(dinA), .rd_i(rdA),
    .dout_o(doutA), .full_o(fullA), .empty_o(emptyA),
    .almost_full_o(afA), .almost_empty_o(aeA), .count_o(countA),
    .overflow_o(ovfA), .underflow_o(unfA)
  );

  sync_fifo_param #(.DATA_W(32), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1)) dutB (
    .clk_i(clk), .rst_ni(rstN), .wr_i(wrB), .din_i(dinB), .rd_i(rdB),
    .dout_o(doutB), .full_o(fullB), .empty_o(emptyB),
    .almost_full_o(afB), .almost_empty_o(aeB), .count_o(countB),
    .overflow_o(ovfB), .underflow_o(unfB)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Each model accepts a read only when it holds data, and a write when there is space or a read frees a slot.
  task automatic modelStepA(input logic w, input logic r, input logic [7:0] d);
    bit rOk, wOk;
    rOk = r && (qA.size() > 0);
    wOk = w && ((qA.size() < 16) || rOk);
    if (rOk) mDoutA = qA.pop_front();
    if (wOk) qA.push_back(d);
    mOvfA = w && !wOk;
    mUnfA = r && !rOk;
  endtask

  task automatic modelStepB(input logic w, input logic r, input logic [31:0] d);
    bit rOk, wOk;
    rOk = r && (qB.size() > 0);
    wOk = w && ((qB.size() < 4) || rOk);
    if (rOk) mDoutB = qB.pop_front();
    if (wOk) qB.push_back(d);
    mOvfB = w && !wOk;
    mUnfB = r && !rOk;
  endtask

  task automatic modelReset();
    qA.delete();
    qB.delete();
    mDoutA = '0; mOvfA = 1'b0; mUnfA = 1'b0;
    mDoutB = '0; mOvfB = 1'b0; mUnfB = 1'b0;
  endtask

  // Drives one cycle of requests to both instances and advances both models.
  // It returns #1 after the next rising edge.
  task automatic applyStimulus(input logic wa, input logic ra, input logic [7:0] da,
                               input logic wb, input logic rb, input logic [31:0] db);
    wrA = wa; rdA = ra; dinA = da;
    wrB = wb; rdB = rb; dinB = db;
    modelStepA(wa, ra, da);
    modelStepB(wb, rb, db);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutputA(input string tag, input int expCount, input logic [7:0] expDout,
                              input logic expOvf, input logic expUnf);
    cmp({tag, " A.count"}, 32'(countA), 32'(expCount));
    cmp({tag, " A.dout"}, 32'(doutA), 32'(expDout));
    cmp({tag, " A.full"}, 32'(fullA), 32'(expCount == 16));
    cmp({tag, " A.empty"}, 32'(emptyA), 32'(expCount == 0));
    cmp({tag, " A.almost_full"}, 32'(afA), 32'(expCount >= 14));
    cmp({tag, " A.almost_empty"}, 32'(aeA), 32'(expCount <= 2));
    cmp({tag, " A.overflow"}, 32'(ovfA), 32'(expOvf));
    cmp({tag, " A.underflow"}, 32'(unfA), 32'(expUnf));
  endtask

  task automatic checkOutputB(input string tag, input int expCount, input logic [31:0] expDout,
                              input logic expOvf, input logic expUnf);
    cmp({tag, " B.count"}, 32'(countB), 32'(expCount));
    cmp({tag, " B.dout"}, doutB, expDout);
    cmp({tag, " B.full"}, 32'(fullB), 32'(expCount == 4));
    cmp({tag, " B.empty"}, 32'(emptyB), 32'(expCount == 0));
    cmp({tag, " B.almost_full"}, 32'(afB), 32'(expCount >= 3));
    cmp({tag, " B.almost_empty"}, 32'(aeB), 32'(expCount <= 1));
    cmp({tag, " B.overflow"}, 32'(ovfB), 32'(expOvf));
    cmp({tag, " B.underflow"}, 32'(unfB), 32'(expUnf));
  endtask

  task automatic checkModelA(input string tag);
    checkOutputA(tag, qA.size(), mDoutA, mOvfA, mUnfA);
  endtask

  task automatic checkModelB(input string tag);
    checkOutputB(tag, qB.size(), mDoutB, mOvfB, mUnfB);
  endtask

  // Moves instance A to the target occupancy with plain writes or reads, checking every cycle.
  task automatic driveToA(input int target);
    for (int k = 0; k < 40 && qA.size() != target; k++) begin
      if (qA.size() < target) applyStimulus(1'b1, 1'b0, 8'(8'hC0 + k), 1'b0, 1'b0, '0);
      else                    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, '0);
      checkModelA("driveTo");
    end
    cmp("driveTo A.count reached", 32'(countA), 32'(target));
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h11, 1, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h22, 2, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 8'h33, 2, 8'h11, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 1, 8'h22, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 0, 8'h33, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 0, 8'h33, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 8'h44, 1, 8'h33, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1, 8'h33, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 8'h00, 0, 8'h44, 1'b0, 1'b0};

    // Reset held for three cycles, then released away from the edge.
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    checkOutputA("reset", 0, 8'h00, 1'b0, 1'b0);
    checkOutputB("reset", 0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      checkModelA("idle");
      checkModelB("idle");
    end

    // Hand-written vectors around the empty boundary.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].din, 1'b0, 1'b0, '0);
      checkOutputA($sformatf("vec%0d", i), vecs[i].expCount, vecs[i].expDout,
                   vecs[i].expOvf, vecs[i].expUnf);
    end

    // Fill with 0x00..0x0F, then drain and expect the same words in order.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, '0);
      checkModelA("fill");
    end
    cmp("fill A.full", 32'(fullA), 32'd1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, '0);
      checkModelA("drain");
      cmp("drain A.order", 32'(doutA), 32'(i));
    end
    cmp("drain A.empty", 32'(emptyA), 32'd1);

    // Overflow at full leaves the contents intact; underflow at empty leaves dout unchanged.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, '0);
    checkOutputA("overflow", 16, 8'h0F, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0);
    checkOutputA("overflow end", 16, 8'h0F, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, '0);
      cmp("intact A.dout", 32'(doutA), 32'(8'h80 + i));
    end
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, '0);
    checkOutputA("underflow", 0, 8'h8F, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0);
    checkOutputA("underflow end", 0, 8'h8F, 1'b0, 1'b0);

    // Simultaneous read and write at occupancy 5, then at full.
    driveToA(5);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, '0);
      checkModelA("simul5");
    end
    driveToA(16);
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, '0);
    checkModelA("simul full");
    cmp("simul full A.overflow", 32'(ovfA), 32'd0);
    driveToA(0);

    // Random traffic alternating between write-heavy and read-heavy phases.
    for (int i = 0; i < 400; i++) begin
      int hi;
      hi = ((i / 50) % 2 == 0) ? 3 : 1;
      applyStimulus(1'($urandom_range(0, 3) < hi), 1'($urandom_range(0, 3) >= hi), 8'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      checkModelA("random");
      checkModelB("random");
    end

    // Asynchronous reset mid-cycle from occupancy 9.
    driveToA(9);
    wrA = 1'b0; rdA = 1'b0; wrB = 1'b0; rdB = 1'b0;
    #2;
    rstN = 1'b0;
    #1;
    modelReset();
    cmp("async A.count", 32'(countA), 32'd0);
    cmp("async A.empty", 32'(emptyA), 32'd1);
    cmp("async B.count", 32'(countB), 32'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    checkOutputA("after reset", 0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 32'h5555_5555);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, '0);
    checkModelA("post reset read");
    checkModelB("post reset read");
    cmp("post reset A.dout", 32'(doutA), 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
